sseg_scan_driver_n: RTL and testbench
=====================================

// Module: sseg_scan_driver_n
// PURPOSE
//  Time-multiplexed N-digit seven-segment display driver. Captures a packed hex/BCD word
//  and per-digit decimal points into a shadow register, then scans the digits one at a time
//  by driving one active-low anode and that digit's active-low segment pattern.
//  Includes its own refresh counter and optional leading-zero blanking.
//  Sits between the note/score logic and the board's anode and segment pins.
// PARAMETERS
//  NUM_DIGITS   4      number of digits scanned (>=1); nibble i drives anode i
//  REFRESH_DIV  50000  clocks each digit stays lit (>=2)
//  IDX_W        $clog2(NUM_DIGITS) (min 1)  width of digit_idx
// PORTS
//  clk        in   1             system clock, rising edge
//  rst        in   1             synchronous reset, active-high
//  value_in   in   4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (rightmost)
//  dp_in      in   NUM_DIGITS    decimal point request per digit, 1 = lit
//  load       in   1             1-cycle strobe: capture value_in/dp_in into shadow
//  enable     in   1             1 = scan/display; 0 = all dark, counters frozen
//  blank_lz   in   1             1 = blank leading zero digits
//  an         out  NUM_DIGITS    anodes, active-low, at most one bit low
//  sseg       out  8             {a,b,c,d,e,f,g,dp}, active-low, bit7 = a, bit0 = dp
//  digit_idx  out  IDX_W         index of the digit currently being driven on an/sseg
//  scan_tick  out  1             1-cycle pulse when the digit index advances
// BEHAVIOUR
//  Reset: shadow value and shadow dp = 0, refresh count = 0, index = 0,
//   an = all 1, sseg = 8'hFF, digit_idx = 0, scan_tick = 0.
//  Shadow: on load=1 the shadow captures value_in/dp_in at that edge.
//   The display reads only the shadow, so updates never tear mid-frame.
//  Refresh: the count runs 0..REFRESH_DIV-1 while enable=1.
//   At terminal count the count returns to 0 and the index steps (NUM_DIGITS-1 wraps to 0).
//   scan_tick is registered and high for the cycle in which the new index is first visible.
//  Outputs: an, sseg and digit_idx are registered from (index, shadow, blank_lz, enable).
//   Latency is 1 clk from any index, shadow or enable change to the pins.
//  Normal drive: an[idx] = 0 and every other anode = 1.
//   sseg = font(nibble[idx]), with bit0 cleared when dp[idx] = 1.
//  Font (dp off): 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 b:C1 C:63 d:85 E:61 F:71.
//   Nibbles 0xA-0xF are shown as hex, never blanked.
//  Leading-zero blanking: digit i>0 is blanked when blank_lz=1, every nibble i..NUM_DIGITS-1
//   is 0, and dp[i] = 0. Blanked means all anodes = 1 and sseg = FF for that slot.
//   The slot still consumes its time. Digit 0 is never blanked.
//  enable=0: next cycle an = all 1, sseg = FF, scan_tick = 0.
//   The count and index hold, and scanning resumes from the held state when enable returns to 1.
//  Simultaneous load and terminal count: the index steps and the shadow updates on the same edge.
//   The next slot shows the new data.
//  rst mid-scan overrides everything, including load and enable, and restores the reset values.
//  NUM_DIGITS=1: index stays 0, scan_tick still pulses every REFRESH_DIV clocks.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4 unless noted)
//  1 Reset: hold rst for 3 clks with load=1 -> an=4'b1111, sseg=FF, shadow unchanged, idx=0.
//  2 Scan: load 16'h1234, dp=0, blank_lz=0 -> an 1110/1101/1011/0111 for 4 clks each,
//    sseg 99,0D,25,9F in that order, scan_tick every 4 clks, wraps to 1110.
//  3 Blanking: load 16'h0070, blank_lz=1 -> digits 3 and 2 dark (an=1111, sseg=FF),
//    digit 1 = 1F, digit 0 = 03. Set dp_in=4'b0100 -> digit 2 lit as 02.
//  4 Hex/dp: load 16'hAbEF with dp_in=4'b0001 -> digit 0 sseg=70, digit 3 = 11.
//  5 Tear-free: pulse load with 16'h5678 on the terminal-count cycle of digit 1 ->
//    digit 2 shows 41 (6) in the next slot, digit 1 never showed a mixed value.
//  6 Enable: drop enable mid-slot for 10 clks -> dark 1 clk later, index/count frozen,
//    the same digit resumes with its remaining clocks. Also run NUM_DIGITS=6, REFRESH_DIV=2.

Source files
------------

// File: rtl/sseg_scan_driver_n.sv
// Multiplexed N-digit seven-segment driver: shadowed value/dp, refresh timer, digit scan,
// leading-zero blanking. Anodes and segments are active-low and registered.
module sseg_scan_driver_n #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    scan_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_step_d;

  logic       w_tc;
  logic [3:0] w_nib;
  logic       w_dp;
  logic       w_upper_zero;
  logic       w_blank;

  function automatic logic [7:0] f_font(input logic [3:0] n);
    case (n)
      4'h0:    f_font = 8'h03;
      4'h1:    f_font = 8'h9F;
      4'h2:    f_font = 8'h25;
      4'h3:    f_font = 8'h0D;
      4'h4:    f_font = 8'h99;
      4'h5:    f_font = 8'h49;
      4'h6:    f_font = 8'h41;
      4'h7:    f_font = 8'h1F;
      4'h8:    f_font = 8'h01;
      4'h9:    f_font = 8'h09;
      4'hA:    f_font = 8'h11;
      4'hB:    f_font = 8'hC1;
      4'hC:    f_font = 8'h63;
      4'hD:    f_font = 8'h85;
      4'hE:    f_font = 8'h61;
      default: f_font = 8'h71;
    endcase
  endfunction

  assign w_tc = enable && (r_cnt == CNT_W'(REFRESH_DIV - 1));

  // Walk from the most significant digit down so w_upper_zero covers nibbles i..N-1.
  always_comb begin
    w_nib        = 4'h0;
    w_dp         = 1'b0;
    w_upper_zero = 1'b1;
    w_blank      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_value[4*i +: 4] != 4'h0) w_upper_zero = 1'b0;
      if (r_idx == IDX_W'(i)) begin
        w_nib   = r_value[4*i +: 4];
        w_dp    = r_dp[i];
        w_blank = (i != 0) && blank_lz && w_upper_zero && !r_dp[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value   <= '0;
      r_dp      <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_step_d  <= 1'b0;
      an        <= '1;
      sseg      <= 8'hFF;
      digit_idx <= '0;
      scan_tick <= 1'b0;
    end else begin
      if (load) begin
        r_value <= value_in;
        r_dp    <= dp_in;
      end
      if (enable) begin
        if (w_tc) begin
          r_cnt <= '0;
          if (r_idx == IDX_W'(NUM_DIGITS - 1)) r_idx <= '0;
          else                                 r_idx <= r_idx + IDX_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      // Tick lines up with the first cycle the new index reaches the pins.
      r_step_d  <= w_tc;
      scan_tick <= r_step_d && enable;
      digit_idx <= r_idx;
      if (!enable || w_blank) begin
        an   <= '1;
        sseg <= 8'hFF;
      end else begin
        an   <= ~(NUM_DIGITS'(1) << r_idx);
        sseg <= f_font(w_nib) & {7'h7F, ~w_dp};
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver_n.sv
// Directed bench for sseg_scan_driver_n: 4-digit/div-4 instance plus a 6-digit/div-2 instance.
module tb_sseg_scan_driver_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value4 = '0;
  logic [3:0]  dp4 = '0;
  logic [23:0] value6 = '0;
  logic [5:0]  dp6 = '0;

  logic [3:0]  an1;
  logic [7:0]  sseg1;
  logic [1:0]  idx1;
  logic        tick1;
  logic [5:0]  an2;
  logic [7:0]  sseg2;
  logic [2:0]  idx2;
  logic        tick2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sseg_scan_driver_n #(.NUM_DIGITS(4), .REFRESH_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .value_in(value4), .dp_in(dp4), .load(load),
    .enable(enable), .blank_lz(blank_lz), .an(an1), .sseg(sseg1),
    .digit_idx(idx1), .scan_tick(tick1)
  );

  sseg_scan_driver_n #(.NUM_DIGITS(6), .REFRESH_DIV(2)) u_dut6 (
    .clk(clk), .rst(rst), .value_in(value6), .dp_in(dp6), .load(load),
    .enable(enable), .blank_lz(blank_lz), .an(an2), .sseg(sseg2),
    .digit_idx(idx2), .scan_tick(tick2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, load the shadow while dark, then enable; the next tick is slot 0, cycle 0.
  task automatic restart(input logic [15:0] v, input logic [3:0] dp, input logic blz);
    rst = 1'b1; load = 1'b0; enable = 1'b0;
    tick();
    rst = 1'b0; load = 1'b1; value4 = v; dp4 = dp; blank_lz = blz;
    tick();
    load = 1'b0; enable = 1'b1;
  endtask

  // an_tbl/ss_tbl hold {digit3..digit0}; k counts lit cycles since enable, 4 per slot.
  task automatic scan4(input string tag, input logic [15:0] an_tbl, input logic [31:0] ss_tbl,
                       input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      int d;
      tick();
      d = (k / 4) % 4;
      check($sformatf("%s_an_k%0d", tag, k), an1, an_tbl[d*4 +: 4]);
      check($sformatf("%s_sseg_k%0d", tag, k), sseg1, ss_tbl[d*8 +: 8]);
      check($sformatf("%s_idx_k%0d", tag, k), idx1, d);
      check($sformatf("%s_tick_k%0d", tag, k), tick1, (k % 4 == 0) && (k > 0));
    end
  endtask

  initial begin
    logic [35:0] an6_tbl;
    logic [47:0] ss6_tbl;

    // 1: reset held with load=1 must not capture; shadow stays 0
    rst = 1'b1; load = 1'b1; enable = 1'b1; value4 = 16'hFFFF; dp4 = 4'hF;
    repeat (3) tick();
    check("rst_an", an1, 4'b1111);
    check("rst_sseg", sseg1, 8'hFF);
    check("rst_idx", idx1, 2'd0);
    check("rst_tick", tick1, 1'b0);
    rst = 1'b0; load = 1'b0; blank_lz = 1'b0;
    tick();
    check("rst_shadow_an", an1, 4'b1110);
    check("rst_shadow_sseg", sseg1, 8'h03);

    // 2: plain scan of 1234 over more than one frame
    restart(16'h1234, 4'b0000, 1'b0);
    scan4("scan", 16'h7BDE, 32'h9F250D99, 0, 20);

    // 3: leading-zero blanking, then a dp keeps digit 2 lit
    restart(16'h0070, 4'b0000, 1'b1);
    scan4("blank", 16'hFFDE, 32'hFFFF1F03, 0, 16);
    restart(16'h0070, 4'b0100, 1'b1);
    scan4("blankdp", 16'hFBDE, 32'hFF021F03, 0, 16);

    // 4: hex glyphs with dp on digit 0
    restart(16'hABEF, 4'b0001, 1'b0);
    scan4("hex", 16'h7BDE, 32'h11C16170, 0, 16);

    // 5: load on digit 1 terminal count; digit 1 finishes old, digit 2 shows new
    restart(16'h1234, 4'b0000, 1'b0);
    scan4("tear_a", 16'h7BDE, 32'h9F250D99, 0, 7);
    load = 1'b1; value4 = 16'h5678;
    scan4("tear_b", 16'h7BDE, 32'h9F250D99, 7, 1);
    load = 1'b0;
    scan4("tear_c", 16'h7BDE, 32'h49411F01, 8, 12);

    // 6: drop enable mid digit-1 slot for 10 clks, resume with remaining clocks
    restart(16'h1234, 4'b0000, 1'b0);
    scan4("en_a", 16'h7BDE, 32'h9F250D99, 0, 6);
    enable = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      check($sformatf("en_off_an_%0d", j), an1, 4'b1111);
      check($sformatf("en_off_sseg_%0d", j), sseg1, 8'hFF);
      check($sformatf("en_off_idx_%0d", j), idx1, 2'd1);
      check($sformatf("en_off_tick_%0d", j), tick1, 1'b0);
    end
    enable = 1'b1;
    scan4("en_b", 16'h7BDE, 32'h9F250D99, 6, 10);

    // 6b: six digits, two clocks per slot, 000321 with blanking
    value6  = 24'h000321;
    dp6     = 6'b000000;
    an6_tbl = {6'h3F, 6'h3F, 6'h3F, 6'b111011, 6'b111101, 6'b111110};
    ss6_tbl = {8'hFF, 8'hFF, 8'hFF, 8'h0D, 8'h25, 8'h9F};
    restart(16'h0000, 4'b0000, 1'b1);
    for (int k = 0; k < 14; k++) begin
      int d;
      tick();
      d = (k / 2) % 6;
      check($sformatf("six_an_k%0d", k), an2, an6_tbl[d*6 +: 6]);
      check($sformatf("six_sseg_k%0d", k), sseg2, ss6_tbl[d*8 +: 8]);
      check($sformatf("six_idx_k%0d", k), idx2, d);
      check($sformatf("six_tick_k%0d", k), tick2, (k % 2 == 0) && (k > 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
